// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl
// Run/halt/step sequencer for the 5-stage RV32I core. A host issues RUN,
// HALT, STEP and LOAD commands; the controller preloads instruction memory
// while the core is halted, resets the core after a program load, gates
// fetch and pipeline advance, stops on a fetch-PC breakpoint and drains the
// pipeline before reporting halted.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            host command handshake
//   cmd_op                         00 RUN, 01 HALT, 10 STEP, 11 LOAD
//   cmd_addr, cmd_data             LOAD word address/data; STEP count in cmd_data
//   cmd_err                        one-cycle pulse for a command illegal in RUN/STEP
//   bp_en, bp_addr, fetch_pc       breakpoint enable/address, core IF-stage PC
//   fetch_en, pipe_en, core_rst    core control
//   imem_we/imem_waddr/imem_wdata  instruction memory write port
//   running, bp_hit, cycle_cnt     status and debug cycle counter
module riscv_run_ctrl #(
  parameter int IMEM_AW      = 6,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [IMEM_AW-1:0] cmd_addr,
  input  logic [31:0]        cmd_data,
  output logic               cmd_err,
  input  logic               bp_en,
  input  logic [31:0]        bp_addr,
  input  logic [31:0]        fetch_pc,
  output logic               fetch_en,
  output logic               pipe_en,
  output logic               core_rst,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               running,
  output logic               bp_hit,
  output logic [CNT_W-1:0]   cycle_cnt
);

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;
  localparam int         DW      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CRST  = 3'd2,
    ST_RUN   = 3'd3,
    ST_STEP  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  state_t             state_r, state_n;
  logic               dirty_r, dirty_n;
  logic               pend_step_r, pend_step_n;
  logic               first_r, first_n;
  logic               bp_hit_r, bp_hit_n;
  logic               cmd_err_r, cmd_err_n;
  logic [31:0]        step_cnt_r, step_cnt_n;
  logic [DW-1:0]      drain_cnt_r, drain_cnt_n;
  logic [IMEM_AW-1:0] load_addr_r, load_addr_n;
  logic [31:0]        load_data_r, load_data_n;
  logic [CNT_W-1:0]   cycle_cnt_r;
  logic               active_s;
  logic               accept_s;
  logic               bp_match_s;

  assign active_s   = (state_r == ST_RUN) || (state_r == ST_STEP);
  assign cmd_ready  = (state_r == ST_IDLE) || active_s;
  assign accept_s   = cmd_valid && cmd_ready;
  // The first fetch after entering RUN/STEP is exempt so a resume from the
  // breakpoint PC does not immediately stop again.
  assign bp_match_s = active_s && bp_en && (fetch_pc == bp_addr) && !first_r;

  // The breakpoint gating is the only combinational input-to-output path.
  assign fetch_en   = active_s && !bp_match_s;
  assign pipe_en    = active_s || (state_r == ST_DRAIN);
  assign core_rst   = (state_r == ST_CRST);
  assign imem_we    = (state_r == ST_LOAD);
  assign imem_waddr = load_addr_r;
  assign imem_wdata = load_data_r;
  assign running    = active_s;
  assign bp_hit     = bp_hit_r;
  assign cmd_err    = cmd_err_r;
  assign cycle_cnt  = cycle_cnt_r;

  // Next-state and next-register-value logic for the sequencer.
  always_comb begin
    state_n     = state_r;
    dirty_n     = dirty_r;
    pend_step_n = pend_step_r;
    bp_hit_n    = bp_hit_r;
    cmd_err_n   = 1'b0;
    step_cnt_n  = step_cnt_r;
    drain_cnt_n = drain_cnt_r;
    load_addr_n = load_addr_r;
    load_data_n = load_data_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_LOAD: begin
              state_n     = ST_LOAD;
              load_addr_n = cmd_addr;
              load_data_n = cmd_data;
              dirty_n     = 1'b1;
            end
            OP_RUN: begin
              bp_hit_n    = 1'b0;
              pend_step_n = 1'b0;
              state_n     = dirty_r ? ST_CRST : ST_RUN;
            end
            OP_STEP: begin
              bp_hit_n    = 1'b0;
              pend_step_n = 1'b1;
              step_cnt_n  = (cmd_data == 32'd0) ? 32'd1 : cmd_data;
              state_n     = dirty_r ? ST_CRST : ST_STEP;
            end
            default: begin
              state_n = ST_IDLE;
            end
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_n = ST_IDLE;
      end
      ST_CRST: begin
        dirty_n = 1'b0;
        state_n = pend_step_r ? ST_STEP : ST_RUN;
      end
      ST_RUN, ST_STEP: begin
        if (accept_s && (cmd_op != OP_HALT)) begin
          cmd_err_n = 1'b1;
        end else begin
          cmd_err_n = 1'b0;
        end
        // Breakpoint, halt and step expiry all funnel into a single drain.
        if (bp_match_s) begin
          bp_hit_n    = 1'b1;
          state_n     = ST_DRAIN;
          drain_cnt_n = DW'(DRAIN_CYCLES - 1);
        end else if (accept_s && (cmd_op == OP_HALT)) begin
          state_n     = ST_DRAIN;
          drain_cnt_n = DW'(DRAIN_CYCLES - 1);
        end else if ((state_r == ST_STEP) && (step_cnt_r == 32'd1)) begin
          state_n     = ST_DRAIN;
          drain_cnt_n = DW'(DRAIN_CYCLES - 1);
        end else if (state_r == ST_STEP) begin
          step_cnt_n  = step_cnt_r - 32'd1;
        end else begin
          state_n     = state_r;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == {DW{1'b0}}) begin
          state_n = ST_IDLE;
        end else begin
          drain_cnt_n = drain_cnt_r - DW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    first_n = ((state_n == ST_RUN) || (state_n == ST_STEP)) && !active_s;
  end

  // Sequencer state and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      dirty_r     <= 1'b0;
      pend_step_r <= 1'b0;
      first_r     <= 1'b0;
      bp_hit_r    <= 1'b0;
      cmd_err_r   <= 1'b0;
      step_cnt_r  <= 32'd0;
      drain_cnt_r <= {DW{1'b0}};
      load_addr_r <= {IMEM_AW{1'b0}};
      load_data_r <= 32'd0;
    end else begin
      state_r     <= state_n;
      dirty_r     <= dirty_n;
      pend_step_r <= pend_step_n;
      first_r     <= first_n;
      bp_hit_r    <= bp_hit_n;
      cmd_err_r   <= cmd_err_n;
      step_cnt_r  <= step_cnt_n;
      drain_cnt_r <= drain_cnt_n;
      load_addr_r <= load_addr_n;
      load_data_r <= load_data_n;
    end
  end

  // Saturating count of pipeline-advance cycles since the last core reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_CRST) begin
      cycle_cnt_r <= {CNT_W{1'b0}};
    end else if (pipe_en && (cycle_cnt_r != {CNT_W{1'b1}})) begin
      cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed testbench for riscv_run_ctrl: inputs are driven and outputs are
// sampled on the falling edge; expected values are hand-computed constants.
module tb_riscv_run_ctrl;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [5:0]  cmd_addr = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        cmd_err;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] fetch_pc = 32'd0;
  logic        fetch_en, pipe_en, core_rst, imem_we, running, bp_hit;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int errors = 0;
  int pe, fe;

  riscv_run_ctrl #(.IMEM_AW(6), .DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_err(cmd_err),
    .bp_en(bp_en), .bp_addr(bp_addr), .fetch_pc(fetch_pc),
    .fetch_en(fetch_en), .pipe_en(pipe_en), .core_rst(core_rst),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .running(running), .bp_hit(bp_hit), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command for one rising edge; returns on the following falling edge.
  task automatic cmd(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Count pipe_en/fetch_en cycles until pipe_en drops (bounded).
  task automatic count_pipe(output int p, output int f);
    p = 0;
    f = 0;
    while ((pipe_en === 1'b1) && (p < 40)) begin
      p++;
      if (fetch_en === 1'b1) f++;
      @(negedge clk);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_fetch"}, {31'd0, fetch_en}, 32'd0);
    chk({tag, "_pipe"}, {31'd0, pipe_en}, 32'd0);
    chk({tag, "_crst"}, {31'd0, core_rst}, 32'd0);
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_err"}, {31'd0, cmd_err}, 32'd0);
    chk({tag, "_run"}, {31'd0, running}, 32'd0);
    chk({tag, "_bphit"}, {31'd0, bp_hit}, 32'd0);
    chk({tag, "_cnt"}, cycle_cnt, 32'd0);
  endtask

  initial begin
    // Reset, then idle five cycles
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset("idle");

    // LOAD addr 3 -> one write cycle
    cmd(OP_LOAD, 6'd3, 32'h00A00513);
    chk("load_we", {31'd0, imem_we}, 32'd1);
    chk("load_addr", {26'd0, imem_waddr}, 32'd3);
    chk("load_data", imem_wdata, 32'h00A00513);
    chk("load_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("load_we_off", {31'd0, imem_we}, 32'd0);
    chk("load_back_idle", {31'd0, cmd_ready}, 32'd1);

    // RUN after load -> core reset cycle, then enables
    cmd(OP_RUN, 6'd0, 32'd0);
    chk("crst_pulse", {31'd0, core_rst}, 32'd1);
    chk("crst_fetch", {31'd0, fetch_en}, 32'd0);
    chk("crst_pipe", {31'd0, pipe_en}, 32'd0);
    @(negedge clk);
    chk("run_crst_off", {31'd0, core_rst}, 32'd0);
    chk("run_fetch", {31'd0, fetch_en}, 32'd1);
    chk("run_pipe", {31'd0, pipe_en}, 32'd1);
    chk("run_running", {31'd0, running}, 32'd1);
    chk("run_cnt0", cycle_cnt, 32'd0);
    @(negedge clk);
    chk("run_cnt1", cycle_cnt, 32'd1);

    // LOAD during RUN is illegal
    cmd(OP_LOAD, 6'd7, 32'hDEADBEEF);
    chk("runload_err", {31'd0, cmd_err}, 32'd1);
    chk("runload_we", {31'd0, imem_we}, 32'd0);
    chk("runload_running", {31'd0, running}, 32'd1);
    @(negedge clk);
    chk("runload_err_pulse", {31'd0, cmd_err}, 32'd0);

    // HALT in RUN -> 4 drain cycles; 4 run + 4 drain cycles counted
    cmd(OP_HALT, 6'd0, 32'd0);
    chk("halt_fetch", {31'd0, fetch_en}, 32'd0);
    chk("halt_running", {31'd0, running}, 32'd0);
    chk("halt_ready", {31'd0, cmd_ready}, 32'd0);
    count_pipe(pe, fe);
    chk("halt_drain_len", pe, 32'd4);
    chk("halt_idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("halt_cnt", cycle_cnt, 32'd8);

    // STEP 5 from clean IDLE
    cmd(OP_STEP, 6'd0, 32'd5);
    chk("step5_crst", {31'd0, core_rst}, 32'd0);
    count_pipe(pe, fe);
    chk("step5_fetch", fe, 32'd5);
    chk("step5_pipe", pe, 32'd9);
    chk("step5_ready", {31'd0, cmd_ready}, 32'd1);
    chk("step5_cnt", cycle_cnt, 32'd17);

    // STEP 0 behaves as STEP 1
    cmd(OP_STEP, 6'd0, 32'd0);
    count_pipe(pe, fe);
    chk("step0_fetch", fe, 32'd1);
    chk("step0_pipe", pe, 32'd5);
    chk("step0_cnt", cycle_cnt, 32'd22);

    // HALT in IDLE is a silent no-op
    cmd(OP_HALT, 6'd0, 32'd0);
    chk("idlehalt_err", {31'd0, cmd_err}, 32'd0);
    chk("idlehalt_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idlehalt_running", {31'd0, running}, 32'd0);

    // HALT on the final STEP cycle -> single drain
    cmd(OP_STEP, 6'd0, 32'd3);
    @(negedge clk);
    @(negedge clk);
    cmd(OP_HALT, 6'd0, 32'd0);
    chk("laststep_err", {31'd0, cmd_err}, 32'd0);
    chk("laststep_fetch", {31'd0, fetch_en}, 32'd0);
    count_pipe(pe, fe);
    chk("laststep_drain", pe, 32'd4);
    chk("laststep_cnt", cycle_cnt, 32'd29);
    chk("laststep_ready", {31'd0, cmd_ready}, 32'd1);

    // Breakpoint at 0x10
    bp_en    = 1'b1;
    bp_addr  = 32'h10;
    fetch_pc = 32'h0;
    cmd(OP_RUN, 6'd0, 32'd0);
    #1;
    chk("bp_pc0_fetch", {31'd0, fetch_en}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      fetch_pc = 32'(i * 4);
      #1;
      chk("bp_pre_fetch", {31'd0, fetch_en}, 32'd1);
    end
    @(negedge clk);
    fetch_pc = 32'h10;
    #1;
    chk("bp_match_fetch", {31'd0, fetch_en}, 32'd0);
    chk("bp_match_running", {31'd0, running}, 32'd1);
    @(negedge clk);
    chk("bp_hit_set", {31'd0, bp_hit}, 32'd1);
    chk("bp_drain_fetch", {31'd0, fetch_en}, 32'd0);
    count_pipe(pe, fe);
    chk("bp_drain_len", pe, 32'd4);
    chk("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("bp_hit_sticky", {31'd0, bp_hit}, 32'd1);

    // Resume from the breakpoint PC: no immediate re-hit
    cmd(OP_RUN, 6'd0, 32'd0);
    #1;
    chk("resume_fetch", {31'd0, fetch_en}, 32'd1);
    chk("resume_bphit", {31'd0, bp_hit}, 32'd0);
    @(negedge clk);
    fetch_pc = 32'h14;
    #1;
    chk("resume_running", {31'd0, running}, 32'd1);
    chk("resume_fetch2", {31'd0, fetch_en}, 32'd1);
    @(negedge clk);
    cmd(OP_HALT, 6'd0, 32'd0);
    count_pipe(pe, fe);
    chk("resume_drain", pe, 32'd4);
    chk("resume_bphit_after", {31'd0, bp_hit}, 32'd0);
    bp_en = 1'b0;

    // Reset in the middle of DRAIN
    cmd(OP_RUN, 6'd0, 32'd0);
    cmd(OP_HALT, 6'd0, 32'd0);
    @(negedge clk);
    chk("middrain_pipe", {31'd0, pipe_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_drain");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of LOAD
    cmd(OP_LOAD, 6'd5, 32'h12345678);
    chk("midload_we", {31'd0, imem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_load");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // RUN after reset: the interrupted load left nothing dirty
    cmd(OP_RUN, 6'd0, 32'd0);
    chk("postrst_crst", {31'd0, core_rst}, 32'd0);
    chk("postrst_fetch", {31'd0, fetch_en}, 32'd1);
    cmd(OP_HALT, 6'd0, 32'd0);
    count_pipe(pe, fe);
    chk("postrst_drain", pe, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
